axis_mem_write_arbiter: RTL and testbench
=========================================

Name: axis_mem_write_arbiter

Overview:
Two-input, packet-granular round-robin arbiter that shares the single AXI-Stream write port of the on-chip memory controller between two producers. It locks onto one source from grant until that source's tlast beat, then releases and re-arbitrates. It also reports the source ID for each packet, enforces a maximum packet length, and keeps per-source packet counters for software visibility.

Parameters:
DATA_WIDTH, 32, tdata width; tstrb width is DATA_WIDTH/8
MAX_BEATS, 256, maximum beats per granted packet before a forced split; must be 2..65535
CNT_WIDTH, 16, width of the per-source packet counters

Ports:
axis_aclk  input  1  single clock for all logic
axis_areset  input  1  asynchronous, active-high reset
s00_axis_tdata  input  DATA_WIDTH  source 0 data
s00_axis_tstrb  input  DATA_WIDTH/8  source 0 byte strobes
s00_axis_tvalid  input  1  source 0 valid
s00_axis_tlast  input  1  source 0 end of packet
s00_axis_tready  output  1  source 0 ready
s01_axis_tdata  input  DATA_WIDTH  source 1 data
s01_axis_tstrb  input  DATA_WIDTH/8  source 1 byte strobes
s01_axis_tvalid  input  1  source 1 valid
s01_axis_tlast  input  1  source 1 end of packet
s01_axis_tready  output  1  source 1 ready
m00_axis_tdata  output  DATA_WIDTH  data to the memory controller write port
m00_axis_tstrb  output  DATA_WIDTH/8  strobes to the memory controller
m00_axis_tvalid  output  1  valid to the memory controller
m00_axis_tlast  output  1  end of packet (source tlast, or forced at MAX_BEATS)
m00_axis_tuser  output  1  granted source ID (0 or 1)
m00_axis_tready  input  1  ready from the memory controller
pkt_cnt0  output  CNT_WIDTH  count of completed source 0 packets
pkt_cnt1  output  CNT_WIDTH  count of completed source 1 packets
split_err  output  1  sticky flag: a packet was split at MAX_BEATS

Behaviour:
- Reset (async, active-high): state=IDLE, rr_last=1 (source 0 wins the first tie), beat_cnt=0, pkt_cnt0=pkt_cnt1=0, split_err=0. While in reset or IDLE, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tuser=0, m00_axis_tdata=0, m00_axis_tstrb=0, and both s*_tready=0.
- States: IDLE, BUSY0, BUSY1 (registered).
- IDLE arbitration:
  - Only s00 tvalid -> BUSY0. Only s01 tvalid -> BUSY1.
  - Both valid -> grant the source != rr_last. rr_last updates to the granted source on the grant edge.
  - Neither valid -> stay in IDLE.
  - Arbitration costs 1 cycle. No beat is transferred in the cycle spent in IDLE.
- BUSYn datapath (combinational, zero added latency):
  - m00 tdata, tstrb and tvalid = sn's signals; m00_axis_tuser=n.
  - sn_tready = m00_axis_tready; the other source's tready=0.
  - m00_axis_tlast = sn_tlast OR (beat_cnt==MAX_BEATS-1).
- Handshake = m00_axis_tvalid & m00_axis_tready. Each handshake increments beat_cnt.
- Handshake with m00_axis_tlast=1:
  - beat_cnt<=0 and state<=IDLE, so there is always one idle bubble between packets.
  - pkt_cntn increments and wraps modulo 2^CNT_WIDTH.
  - If the source tlast was 0 (forced split), split_err<=1 and stays set until reset. The source's remaining beats compete as a new packet.
- The source must hold tvalid and tdata stable until handshake; the arbiter does not buffer data. A source dropping tvalid mid-packet keeps the grant (no timeout).
- Simultaneous events:
  - A source tlast beat on exactly beat MAX_BEATS counts as a normal end; split_err is not set.
  - A new request arriving while BUSY is only considered at the next IDLE cycle.
- Reset mid-packet: immediate return to IDLE with all outputs at reset values. A partial packet already in memory is not the arbiter's concern.
- Fairness: with both sources continuously requesting, grants alternate strictly 0,1,0,1.

Test Plan:
1. Reset, then s00 sends a 4-beat packet (0xA0..0xA3) with m00_tready=1 -> one IDLE cycle, then 4 consecutive m00 beats with tuser=0, tlast on 0xA3, pkt_cnt0=1, s01_tready=0 throughout.
2. Both sources hold 3-beat packets valid from reset -> order is s00 packet, bubble, s01 packet, bubble, s00 packet; tuser sequence 0,1,0; pkt_cnt0=2, pkt_cnt1=1.
3. Backpressure: m00_tready toggles 1,0,1,0 during an s01 packet -> s01_tready mirrors m00_tready each cycle; no beat is lost or duplicated; data order is preserved.
4. MAX_BEATS=4, s00 sends 6 beats with tlast only on beat 6 -> m00_tlast on beat 4, split_err=1, re-arbitration, beats 5-6 emitted as a second packet, pkt_cnt0=2.
5. Assert axis_areset after beat 2 of a 5-beat s01 packet -> m00_tvalid=0 and tready=0 immediately; counters clear; after release, s00 is granted first on a tie.
6. Set pkt_cnt1 to 0xFFFE via 0xFFFE single-beat packets, then send two more -> counter wraps 0xFFFF then 0x0000.

Source files
------------

// File: rtl/axis_mem_write_arbiter_if.sv
// axis_mem_write_arbiter_if: AXI-Stream bundle linking the arbiter to its producers and to the memory write port
interface axis_mem_write_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic tvalid;
  logic tlast;
  logic tuser;
  logic tready;
  modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_mem_write_arbiter.sv
// axis_mem_write_arbiter: packet-granular round-robin sharing of one AXI-Stream write port between two sources
module axis_mem_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS = 256,
  parameter int CNT_WIDTH = 16
) (
  input  logic axis_aclk,
  input  logic axis_areset,
  axis_mem_write_arbiter_if.slave s00_axis,
  axis_mem_write_arbiter_if.slave s01_axis,
  axis_mem_write_arbiter_if.master m00_axis,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1,
  output logic split_err
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t r_state;
  logic r_rr_last;
  logic [15:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_pkt_cnt0, r_pkt_cnt1;
  logic r_split_err;
  logic w_busy, w_sel, w_src_last, w_hs;
  assign w_busy = r_state != IDLE;
  assign w_sel = r_state == BUSY1;
  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;
  assign split_err = r_split_err;
  // route the granted source straight through; everything is quiet while arbitrating
  always_comb begin
    m00_axis.tvalid = w_busy & (w_sel ? s01_axis.tvalid : s00_axis.tvalid);
    m00_axis.tdata = w_busy ? (w_sel ? s01_axis.tdata : s00_axis.tdata) : '0;
    m00_axis.tstrb = w_busy ? (w_sel ? s01_axis.tstrb : s00_axis.tstrb) : '0;
    m00_axis.tuser = w_sel;
    w_src_last = w_sel ? s01_axis.tlast : s00_axis.tlast;
    m00_axis.tlast = w_busy & (w_src_last | (r_beat_cnt == 16'(MAX_BEATS - 1)));
    s00_axis.tready = (r_state == BUSY0) & m00_axis.tready;
    s01_axis.tready = w_sel & m00_axis.tready;
    w_hs = m00_axis.tvalid & m00_axis.tready;
  end
  // grant on a tie goes to the source that did not win last; the grant holds until the closing beat
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      r_state <= IDLE;
      r_rr_last <= 1'b1;
      r_beat_cnt <= '0;
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
      r_split_err <= 1'b0;
    end else if (!w_busy) begin
      if (s00_axis.tvalid & (!s01_axis.tvalid | r_rr_last)) begin
        r_state <= BUSY0;
        r_rr_last <= 1'b0;
      end else if (s01_axis.tvalid) begin
        r_state <= BUSY1;
        r_rr_last <= 1'b1;
      end
    end else if (w_hs) begin
      if (m00_axis.tlast) begin
        r_state <= IDLE;
        r_beat_cnt <= '0;
        if (w_sel) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_WIDTH'(1);
        else r_pkt_cnt0 <= r_pkt_cnt0 + CNT_WIDTH'(1);
        if (!w_src_last) r_split_err <= 1'b1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axis_mem_write_arbiter.sv
// tb_axis_mem_write_arbiter: directed vectors plus queue-model scoreboard for the two-source write arbiter
module tb_axis_mem_write_arbiter;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int CW = 8;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] cnt0, cnt1;
  logic split;
  always #5 clk = ~clk;
  axis_mem_write_arbiter_if #(.DATA_WIDTH(DW)) s0 ();
  axis_mem_write_arbiter_if #(.DATA_WIDTH(DW)) s1 ();
  axis_mem_write_arbiter_if #(.DATA_WIDTH(DW)) m ();
  assign s0.tuser = 1'b0;
  assign s1.tuser = 1'b0;
  axis_mem_write_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
    .axis_aclk(clk), .axis_areset(rst),
    .s00_axis(s0), .s01_axis(s1), .m00_axis(m),
    .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .split_err(split)
  );
  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  typedef struct packed {logic [31:0] d; logic u; logic l;} obeat_t;
  typedef struct {
    logic s0v; logic [31:0] s0d; logic s0l;
    logic s1v; logic [31:0] s1d; logic s1l;
    logic mr;
    logic mv; logic tu; logic tl; logic [31:0] td; logic s0r; logic s1r;
    logic [7:0] c0; logic [7:0] c1;
  } vec_t;
  int n_vec = 0;
  int n_miss = 0;
  beat_t sq [2][$];
  obeat_t expq[$];
  int mdl_last;
  int mdl_cnt [2];
  logic mdl_split;
  vec_t tbl [13];
  function automatic logic [3:0] strb_of(logic [31:0] d);
    return d[3:0] ^ 4'h5;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic set_srcs();
    s0.tvalid = sq[0].size() != 0;
    s0.tdata = s0.tvalid ? sq[0][0].d : '0;
    s0.tlast = s0.tvalid ? sq[0][0].l : 1'b0;
    s0.tstrb = strb_of(s0.tdata);
    s1.tvalid = sq[1].size() != 0;
    s1.tdata = s1.tvalid ? sq[1][0].d : '0;
    s1.tlast = s1.tvalid ? sq[1][0].l : 1'b0;
    s1.tstrb = strb_of(s1.tdata);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sq[0].delete();
    sq[1].delete();
    expq.delete();
    set_srcs();
    m.tready = 1'b1;
    @(posedge clk);
    #1;
    s0.tvalid = 1'b1;
    s1.tvalid = 1'b1;
    #1;
    chk("reset_outputs", 64'({m.tvalid, m.tlast, m.tuser, m.tdata, m.tstrb, s0.tready, s1.tready, cnt0, cnt1, split}), 64'(0));
    set_srcs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_last = 1;
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;
    mdl_split = 1'b0;
  endtask
  task automatic push_pkt(input int s, input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) sq[s].push_back(beat_t'{d: base + 32'(i), l: (i == len - 1)});
  endtask
  task automatic build_exp();
    int p [2];
    int s;
    int n;
    bit done;
    beat_t b;
    p[0] = 0;
    p[1] = 0;
    while (p[0] < sq[0].size() || p[1] < sq[1].size()) begin
      if (p[0] < sq[0].size() && p[1] < sq[1].size()) s = (mdl_last == 0) ? 1 : 0;
      else s = (p[0] < sq[0].size()) ? 0 : 1;
      n = 0;
      done = 1'b0;
      while (!done && p[s] < sq[s].size()) begin
        b = sq[s][p[s]];
        p[s]++;
        n++;
        done = b.l || (n == MB);
        if (n == MB && !b.l) mdl_split = 1'b1;
        expq.push_back(obeat_t'{d: b.d, u: s[0], l: done});
      end
      mdl_cnt[s]++;
      mdl_last = s;
    end
  endtask
  task automatic run_stream(input int pct, output int cycles);
    obeat_t e;
    build_exp();
    cycles = 0;
    while (expq.size() != 0 && cycles < 20000) begin
      set_srcs();
      m.tready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (m.tvalid && m.tready) begin
        e = expq.pop_front();
        chk("beat", 64'({m.tdata, m.tstrb, m.tuser, m.tlast, s0.tready, s1.tready}),
            64'({e.d, strb_of(e.d), e.u, e.l, !e.u, e.u}));
        if (sq[e.u].size() != 0) void'(sq[e.u].pop_front());
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    if (expq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL stream_timeout: got %0d beats left expected 0", expq.size());
      expq.delete();
      sq[0].delete();
      sq[1].delete();
    end
    set_srcs();
    m.tready = 1'b1;
    chk("counters", 64'({cnt0, cnt1, split}), 64'({CW'(mdl_cnt[0]), CW'(mdl_cnt[1]), mdl_split}));
  endtask
  initial begin
    int c;
    tbl[0]  = '{T, 32'hA0, F, F, 32'h0, F, T, F, F, F, 32'h0,  F, F, 8'd0, 8'd0};
    tbl[1]  = '{T, 32'hA0, F, F, 32'h0, F, T, T, F, F, 32'hA0, T, F, 8'd0, 8'd0};
    tbl[2]  = '{T, 32'hA1, F, F, 32'h0, F, T, T, F, F, 32'hA1, T, F, 8'd0, 8'd0};
    tbl[3]  = '{T, 32'hA2, F, F, 32'h0, F, T, T, F, F, 32'hA2, T, F, 8'd0, 8'd0};
    tbl[4]  = '{T, 32'hA3, T, F, 32'h0, F, T, T, F, T, 32'hA3, T, F, 8'd0, 8'd0};
    tbl[5]  = '{F, 32'h0,  F, F, 32'h0, F, T, F, F, F, 32'h0,  F, F, 8'd1, 8'd0};
    tbl[6]  = '{F, 32'h0,  F, T, 32'hB0, F, T, F, F, F, 32'h0,  F, F, 8'd1, 8'd0};
    tbl[7]  = '{F, 32'h0,  F, T, 32'hB0, F, T, T, T, F, 32'hB0, F, T, 8'd1, 8'd0};
    tbl[8]  = '{F, 32'h0,  F, T, 32'hB1, F, F, T, T, F, 32'hB1, F, F, 8'd1, 8'd0};
    tbl[9]  = '{F, 32'h0,  F, T, 32'hB1, F, T, T, T, F, 32'hB1, F, T, 8'd1, 8'd0};
    tbl[10] = '{F, 32'h0,  F, T, 32'hB2, T, F, T, T, T, 32'hB2, F, F, 8'd1, 8'd0};
    tbl[11] = '{F, 32'h0,  F, T, 32'hB2, T, T, T, T, T, 32'hB2, F, T, 8'd1, 8'd0};
    tbl[12] = '{F, 32'h0,  F, F, 32'h0, F, T, F, F, F, 32'h0,  F, F, 8'd1, 8'd1};
    m.tready = 1'b1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      s0.tvalid = tbl[i].s0v; s0.tdata = tbl[i].s0d; s0.tlast = tbl[i].s0l; s0.tstrb = strb_of(tbl[i].s0d);
      s1.tvalid = tbl[i].s1v; s1.tdata = tbl[i].s1d; s1.tlast = tbl[i].s1l; s1.tstrb = strb_of(tbl[i].s1d);
      m.tready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({m.tvalid, m.tuser, m.tlast, m.tdata, s0.tready, s1.tready, cnt0, cnt1}),
          64'({tbl[i].mv, tbl[i].tu, tbl[i].tl, tbl[i].td, tbl[i].s0r, tbl[i].s1r, tbl[i].c0, tbl[i].c1}));
      @(posedge clk);
      #1;
    end
    chk("exact_max_no_split", 64'(split), 64'(0));
    s1.tvalid = 1'b1; s1.tdata = 32'hC0; s1.tlast = 1'b0; s1.tstrb = strb_of(32'hC0);
    m.tready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s1.tdata = 32'hC1; s1.tstrb = strb_of(32'hC1);
    @(posedge clk); #1;
    s1.tdata = 32'hC2; s1.tstrb = strb_of(32'hC2);
    @(negedge clk);
    chk("busy_before_reset", 64'({m.tvalid, m.tuser, m.tdata, s1.tready}), 64'({T, T, 32'hC2, T}));
    rst = 1'b1;
    #1;
    chk("async_reset", 64'({m.tvalid, m.tlast, m.tdata, s0.tready, s1.tready, cnt0, cnt1, split}), 64'(0));
    s0.tvalid = 1'b1; s0.tdata = 32'hD0; s0.tlast = 1'b1; s0.tstrb = strb_of(32'hD0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_release", 64'({m.tvalid, s0.tready, s1.tready}), 64'(0));
    @(negedge clk);
    chk("tie_after_reset", 64'({m.tvalid, m.tuser, m.tlast, m.tdata, s0.tready, s1.tready}), 64'({T, F, T, 32'hD0, T, F}));
    @(posedge clk); #1;
    s0.tvalid = 1'b0; s1.tvalid = 1'b0;
    @(negedge clk);
    chk("after_tie_pkt", 64'({m.tvalid, cnt0, cnt1}), 64'({F, 8'd1, 8'd0}));
    @(posedge clk); #1;
    do_reset();
    push_pkt(0, 6, 32'hE0);
    run_stream(100, c);
    chk("split_cycles", 64'(c), 64'(8));
    do_reset();
    push_pkt(0, 3, 32'h100);
    push_pkt(1, 3, 32'h200);
    push_pkt(0, 3, 32'h300);
    run_stream(100, c);
    chk("fair_cycles", 64'(c), 64'(12));
    for (int k = 0; k < 120; k++) begin
      push_pkt(0, $urandom_range(6, 1), 32'h1000 + 32'(k) * 32'h10);
      if ($urandom_range(3) != 0) push_pkt(1, $urandom_range(6, 1), 32'h8000 + 32'(k) * 32'h10);
    end
    run_stream(70, c);
    do_reset();
    for (int k = 0; k < 254; k++) push_pkt(1, 1, 32'(k) << 8);
    run_stream(100, c);
    chk("cnt1_fe", 64'(cnt1), 64'(8'hFE));
    push_pkt(1, 1, 32'h5A5A);
    run_stream(100, c);
    chk("cnt1_ff", 64'(cnt1), 64'(8'hFF));
    push_pkt(1, 1, 32'h6B6B);
    run_stream(100, c);
    chk("cnt1_wrap", 64'(cnt1), 64'(8'h00));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
